// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, download-loaded instruction memory, stall/redirect/step/halt control
// Optional build macro: IFETCH_ALIGN_CHECK_EN (misaligned redirect halts fetch and raises O_ALIGN_ERR)
module instruction_fetch #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'hF800_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_LOAD_EN,
  input  logic              I_LOAD_WE,
  input  logic [ADDR_W-1:0] I_LOAD_ADDR,
  input  logic [31:0]       I_LOAD_DATA,
  input  logic              I_START,
  input  logic              I_STEP_MODE,
  input  logic              I_STEP,
  input  logic              I_PC_WRITE,
  input  logic              I_BRANCH_TAKEN,
  input  logic [31:0]       I_BRANCH_TARGET,
  input  logic              I_JUMP,
  input  logic [31:0]       I_JUMP_TARGET,
  output logic [31:0]       O_INSTRUCTION,
  output logic [31:0]       O_PC,
  output logic              O_FETCH_VALID,
  output logic              O_FLUSH,
  output logic              O_HALTED,
  output logic [1:0]        O_STATE,
`ifdef IFETCH_ALIGN_CHECK_EN
  output logic              O_ALIGN_ERR,
`endif
  output logic [31:0]       O_CYCLE_COUNT
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_t;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  state_t      state;
  logic [31:0] pc;
  logic [31:0] cycle_count;
  logic        align_err;

  logic [31:0] fetch_word;
  logic        active;
  logic        executing;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] target_aligned;
  logic        misaligned;
  logic        abort;
  logic        is_halt;
  logic        advance;
  logic        halt_take;
  logic [31:0] count_next;

  // Fetch decode: which kind of PC update happens this cycle
  always_comb begin
    fetch_word      = mem[pc[ADDR_W+1:2]];
    executing       = (state == S_RUN) || (state == S_STEP);
    active          = (state == S_RUN) || ((state == S_STEP) && I_STEP);
    redirect        = active && (I_BRANCH_TAKEN || I_JUMP);
    redirect_target = I_BRANCH_TAKEN ? I_BRANCH_TARGET : I_JUMP_TARGET;
    target_aligned  = redirect_target & ~32'h3;
`ifdef IFETCH_ALIGN_CHECK_EN
    misaligned      = redirect && (redirect_target[1:0] != 2'b00);
`else
    misaligned      = 1'b0;
`endif
    abort           = executing && I_LOAD_EN;
    is_halt         = (fetch_word == HALT_WORD);
    advance         = active && !redirect && I_PC_WRITE && !is_halt;
    halt_take       = active && !redirect && I_PC_WRITE && is_halt;
    count_next      = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
  end

  // Program download port; memory is deliberately not reset so a rerun needs no reload
  always_ff @(posedge CLK) begin
    if (state == S_LOAD && I_LOAD_WE) begin
      mem[I_LOAD_ADDR] <= I_LOAD_DATA;
    end
  end

  // Control FSM: state, PC, advancing-cycle counter and sticky alignment error
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_LOAD;
      pc          <= 32'd0;
      cycle_count <= 32'd0;
      align_err   <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          pc <= 32'd0;
          if (I_START) begin
            state       <= I_STEP_MODE ? S_STEP : S_RUN;
            cycle_count <= 32'd0;
          end
        end
        S_RUN, S_STEP: begin
          if (abort) begin
            state     <= S_LOAD;
            pc        <= 32'd0;
            align_err <= 1'b0;
          end else if (misaligned) begin
            state     <= S_HALT;
            align_err <= 1'b1;
          end else if (redirect) begin
            pc          <= target_aligned;
            cycle_count <= count_next;
          end else if (advance) begin
            pc          <= pc + 32'd4;
            cycle_count <= count_next;
          end else if (halt_take) begin
            state <= S_HALT;
          end
        end
        default: begin
          if (I_LOAD_EN) begin
            state     <= S_LOAD;
            pc        <= 32'd0;
            align_err <= 1'b0;
          end
        end
      endcase
    end
  end

  // IF/ID-facing outputs: zero-cycle fetch, bubble whenever no fetch is made
  always_comb begin
    O_INSTRUCTION = active ? fetch_word : NOP_WORD;
    O_FETCH_VALID = active;
    O_PC          = (state == S_LOAD) ? 32'd0 : pc + 32'd4;
    O_FLUSH       = redirect || abort;
    O_HALTED      = (state == S_HALT);
    O_STATE       = state;
    O_CYCLE_COUNT = cycle_count;
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  assign O_ALIGN_ERR = align_err;
`else
  logic unused_align;
  assign unused_align = align_err;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch with behavioural model
module tb_instruction_fetch;
  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] NOPW  = 32'hF800_0000;

  logic          CLK, RESET;
  logic          I_LOAD_EN, I_LOAD_WE, I_START, I_STEP_MODE, I_STEP, I_PC_WRITE;
  logic [AW-1:0] I_LOAD_ADDR;
  logic [31:0]   I_LOAD_DATA, I_BRANCH_TARGET, I_JUMP_TARGET;
  logic          I_BRANCH_TAKEN, I_JUMP;
  logic [31:0]   O_INSTRUCTION, O_PC, O_CYCLE_COUNT;
  logic          O_FETCH_VALID, O_FLUSH, O_HALTED;
  logic [1:0]    O_STATE;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic          O_ALIGN_ERR;
`endif

  instruction_fetch #(.ADDR_W(AW), .HALT_WORD(HALTW), .NOP_WORD(NOPW)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_LOAD_EN(I_LOAD_EN), .I_LOAD_WE(I_LOAD_WE), .I_LOAD_ADDR(I_LOAD_ADDR), .I_LOAD_DATA(I_LOAD_DATA),
    .I_START(I_START), .I_STEP_MODE(I_STEP_MODE), .I_STEP(I_STEP), .I_PC_WRITE(I_PC_WRITE),
    .I_BRANCH_TAKEN(I_BRANCH_TAKEN), .I_BRANCH_TARGET(I_BRANCH_TARGET),
    .I_JUMP(I_JUMP), .I_JUMP_TARGET(I_JUMP_TARGET),
    .O_INSTRUCTION(O_INSTRUCTION), .O_PC(O_PC), .O_FETCH_VALID(O_FETCH_VALID),
    .O_FLUSH(O_FLUSH), .O_HALTED(O_HALTED), .O_STATE(O_STATE),
`ifdef IFETCH_ALIGN_CHECK_EN
    .O_ALIGN_ERR(O_ALIGN_ERR),
`endif
    .O_CYCLE_COUNT(O_CYCLE_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 LOAD, 1 RUN, 2 STEP, 3 HALT
  logic [31:0] m_mem [DEPTH];
  int          m_state;
  logic [31:0] m_pc, m_cnt;
  logic        m_align;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic m_fetching();
    return (m_state == 1) || (m_state == 2 && I_STEP);
  endfunction

  // Model advances on each clock edge from the same inputs the DUT sees
  always @(posedge CLK or posedge RESET) begin : model
    logic [31:0] tgt;
    logic [31:0] w;
    if (RESET) begin
      m_state <= 0; m_pc <= 32'd0; m_cnt <= 32'd0; m_align <= 1'b0;
    end else begin
      w   = m_mem[m_pc[AW+1:2]];
      tgt = I_BRANCH_TAKEN ? I_BRANCH_TARGET : I_JUMP_TARGET;
      if (m_state == 0) begin
        if (I_LOAD_WE) m_mem[I_LOAD_ADDR] <= I_LOAD_DATA;
        m_pc <= 32'd0;
        if (I_START) begin
          m_state <= I_STEP_MODE ? 2 : 1;
          m_cnt   <= 32'd0;
        end
      end else if (m_state == 3) begin
        if (I_LOAD_EN) begin m_state <= 0; m_pc <= 32'd0; m_align <= 1'b0; end
      end else if (I_LOAD_EN) begin
        m_state <= 0; m_pc <= 32'd0; m_align <= 1'b0;
      end else if (m_fetching()) begin
        if (I_BRANCH_TAKEN || I_JUMP) begin
`ifdef IFETCH_ALIGN_CHECK_EN
          if (tgt[1:0] != 2'b00) begin m_state <= 3; m_align <= 1'b1; end else
`endif
          begin m_pc <= {tgt[31:2], 2'b00}; m_cnt <= sat_inc(m_cnt); end
        end else if (I_PC_WRITE) begin
          if (w == HALTW) m_state <= 3;
          else begin m_pc <= m_pc + 32'd4; m_cnt <= sat_inc(m_cnt); end
        end
      end
    end
  end

  // Compare process: every cycle, mid-period, DUT outputs against the model
  always @(negedge CLK) begin
    logic f;
    f = m_fetching();
    chk("instruction", O_INSTRUCTION, f ? m_mem[m_pc[AW+1:2]] : NOPW);
    chk("fetch_valid", {31'd0, O_FETCH_VALID}, {31'd0, f});
    chk("pc_out", O_PC, (m_state == 0) ? 32'd0 : m_pc + 32'd4);
    chk("flush", {31'd0, O_FLUSH},
        {31'd0, (f && (I_BRANCH_TAKEN || I_JUMP)) || ((m_state == 1 || m_state == 2) && I_LOAD_EN)});
    chk("halted", {31'd0, O_HALTED}, {31'd0, m_state == 3});
    chk("state", {30'd0, O_STATE}, m_state[31:0]);
    chk("cycle_count", O_CYCLE_COUNT, m_cnt);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("align_err", {31'd0, O_ALIGN_ERR}, {31'd0, m_align});
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    I_LOAD_EN = 0; I_LOAD_WE = 0; I_START = 0; I_STEP_MODE = 0; I_STEP = 0;
    I_PC_WRITE = 1; I_BRANCH_TAKEN = 0; I_JUMP = 0;
  endtask

  task automatic restart(input logic step_mode);
    I_LOAD_EN = 1; tick(); I_LOAD_EN = 0;
    I_START = 1; I_STEP_MODE = step_mode; tick(); I_START = 0; I_STEP_MODE = 0;
  endtask

  logic [31:0] prog [4];
  int          nvalid;
  logic [31:0] r;

  initial begin
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003; prog[2] = 32'h0022_1820; prog[3] = 32'hFFFF_FFFF;
    idle();
    I_LOAD_ADDR = '0; I_LOAD_DATA = '0; I_BRANCH_TARGET = '0; I_JUMP_TARGET = '0;
    RESET = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", {30'd0, O_STATE}, 32'd0);
    chk("reset_instr", O_INSTRUCTION, NOPW);
    chk("reset_pc", O_PC, 32'd0);
    chk("reset_valid", {31'd0, O_FETCH_VALID}, 32'd0);
    RESET = 0;

    // Fill the whole memory so every address the random phase reaches is known
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom();
      if (r == HALTW) r = 32'd0;
      I_LOAD_WE = 1; I_LOAD_ADDR = i[AW-1:0]; I_LOAD_DATA = r; tick();
    end
    for (int i = 0; i < 4; i++) begin
      I_LOAD_ADDR = i[AW-1:0]; I_LOAD_DATA = prog[i]; tick();
    end
    I_LOAD_WE = 0;

    // Straight-line run into the halt word
    I_START = 1; tick(); I_START = 0;
    chk("run_pc0", O_PC, 32'h4);  tick();
    chk("run_pc1", O_PC, 32'h8);  tick();
    chk("run_pc2", O_PC, 32'hC);  tick();
    chk("run_pc3", O_PC, 32'h10);
    chk("run_halt_instr", O_INSTRUCTION, 32'hFFFF_FFFF);
    chk("run_halt_valid", {31'd0, O_FETCH_VALID}, 32'd1);
    tick();
    chk("halted_flag", {31'd0, O_HALTED}, 32'd1);
    chk("halt_count", O_CYCLE_COUNT, 32'd3);
    chk("halt_nop", O_INSTRUCTION, NOPW);

    // Stall holds PC and instruction
    restart(1'b0);
    I_BRANCH_TAKEN = 1; I_BRANCH_TARGET = 32'h10; tick(); I_BRANCH_TAKEN = 0;
    chk("stall_pre_pc", O_PC, 32'h14);
    I_PC_WRITE = 0; tick(); tick();
    chk("stall_pc", O_PC, 32'h14);
    chk("stall_instr", O_INSTRUCTION, m_mem[4]);
    I_PC_WRITE = 1; tick();
    chk("stall_resume_pc", O_PC, 32'h18);

    // Branch beats jump and overrides a stall
    I_BRANCH_TAKEN = 1; I_BRANCH_TARGET = 32'h40; I_JUMP = 1; I_JUMP_TARGET = 32'h80; I_PC_WRITE = 0;
    #1;
    chk("redirect_flush", {31'd0, O_FLUSH}, 32'd1);
    tick(); idle();
    chk("redirect_pc", O_PC, 32'h44);

    // Single-step: I_STEP on cycles 3 and 7 only
    I_LOAD_EN = 1; #1;
    chk("abort_flush", {31'd0, O_FLUSH}, 32'd1);
    tick(); I_LOAD_EN = 0;
    I_START = 1; I_STEP_MODE = 1; tick(); I_START = 0; I_STEP_MODE = 0;
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      I_STEP = (c == 3 || c == 7);
      #1;
      if (O_FETCH_VALID) nvalid++;
      tick();
    end
    I_STEP = 0;
    chk("step_valid_cycles", nvalid, 32'd2);
    chk("step_pc", O_PC, 32'hC);

    // Asynchronous reset mid-run, then rerun without reload
    restart(1'b0);
    I_BRANCH_TAKEN = 1; I_BRANCH_TARGET = 32'h2C; tick(); I_BRANCH_TAKEN = 0;
    chk("pre_reset_pc", O_PC, 32'h30);
    #2 RESET = 1;
    #1;
    chk("async_reset_state", {30'd0, O_STATE}, 32'd0);
    chk("async_reset_pc", O_PC, 32'd0);
    @(posedge CLK); #1 RESET = 0;
    I_START = 1; tick(); I_START = 0;
    chk("rerun_instr", O_INSTRUCTION, 32'h2001_0005);
    repeat (4) tick();
    chk("rerun_halted", {31'd0, O_HALTED}, 32'd1);
    chk("rerun_count", O_CYCLE_COUNT, 32'd3);

`ifdef IFETCH_ALIGN_CHECK_EN
    restart(1'b0);
    I_BRANCH_TAKEN = 1; I_BRANCH_TARGET = 32'h42; tick(); I_BRANCH_TAKEN = 0;
    chk("align_state", {30'd0, O_STATE}, 32'd3);
    chk("align_flag", {31'd0, O_ALIGN_ERR}, 32'd1);
    I_LOAD_EN = 1; tick(); I_LOAD_EN = 0;
    chk("align_cleared", {31'd0, O_ALIGN_ERR}, 32'd0);
`endif

    // Randomized phase driven by the model's state
    for (int i = 0; i < 4000; i++) begin
      idle();
      I_LOAD_WE   = ($urandom_range(0, 3) == 0);
      I_LOAD_ADDR = AW'($urandom_range(0, 127));
      I_LOAD_DATA = ($urandom_range(0, 3) == 0) ? HALTW : $urandom();
      I_BRANCH_TARGET = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 511);
      I_JUMP_TARGET   = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 511);
      case (m_state)
        0: begin
          I_START     = ($urandom_range(0, 2) == 0);
          I_STEP_MODE = $urandom_range(0, 1);
        end
        3: I_LOAD_EN = ($urandom_range(0, 3) == 0);
        default: begin
          I_STEP         = $urandom_range(0, 1);
          I_PC_WRITE     = ($urandom_range(0, 4) != 0);
          I_BRANCH_TAKEN = ($urandom_range(0, 9) == 0);
          I_JUMP         = ($urandom_range(0, 9) == 0);
          I_LOAD_EN      = ($urandom_range(0, 49) == 0);
        end
      endcase
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
